// File: rtl/deemph_mac_sched.sv
// deemph_mac_sched
// Stereo first-order de-emphasis with one shared 32x16 signed multiplier.
//    y = (x*A >>> 15) + (y_prev*B >>> 15), computed per channel, L then R.
// The FSM issues four products per stereo frame. The x*A term is registered.
// The y_prev*B product is combined with that term in the next cycle.
//
// Ports
//    clk, rst             clock, synchronous active-high reset
//    in_valid/in_ready    input frame handshake (in_l, in_r: signed 24-bit)
//    enable               de-emphasis on/off, captured at accept (off = bypass)
//    coef_load            1-cycle strobe staging coef_a / coef_b (signed Q1.15)
//    out_valid/out_ready  output frame handshake (out_l, out_r: signed 24-bit)
//    busy                 FSM is not idle
//
// Configuration macro
//    DEEMPH_SAT_EN  when defined, clamps the 33-bit sum to the signed 32-bit range
//                   instead of letting it wrap.

module deemph_mac_sched #(
   parameter logic signed [15:0] A_INIT = 16'sd32000,
   parameter logic signed [15:0] B_INIT = 16'sd512
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic signed [23:0] in_l,
   input  logic signed [23:0] in_r,
   input  logic               enable,
   input  logic               coef_load,
   input  logic signed [15:0] coef_a,
   input  logic signed [15:0] coef_b,
   output logic               out_valid,
   input  logic               out_ready,
   output logic signed [23:0] out_l,
   output logic signed [23:0] out_r,
   output logic               busy
);

   typedef enum logic [2:0] {IDLE, ML_X, ML_Y, MR_X, MR_Y, HOLD} state_t;

   state_t             state;
   logic signed [23:0] xl, xr;
   logic signed [31:0] yl, yr;
   logic               en_q;
   logic signed [15:0] a_act, b_act, a_stg, b_stg;
   logic signed [31:0] term_q;

   logic signed [31:0] mul_a;
   logic signed [15:0] mul_b;
   logic signed [47:0] mult;
   logic signed [31:0] term_m;
   logic signed [31:0] y_new;

   // Operand select for the shared multiplier.
   // The x states use the sample padded to 32 bits with A.
   // The y states use the stored feedback value with B.
   always_comb begin
      mul_a = {xl, 8'h00};
      mul_b = a_act;
      case (state)
         ML_Y:    begin mul_a = yl;          mul_b = b_act; end
         MR_X:    begin mul_a = {xr, 8'h00}; mul_b = a_act; end
         MR_Y:    begin mul_a = yr;          mul_b = b_act; end
         default: begin mul_a = {xl, 8'h00}; mul_b = a_act; end
      endcase
      mult   = 48'(mul_a) * 48'(mul_b);
      term_m = 32'(mult >>> 15);
   end

   // Combine the registered x term with the live y term.
   // Wrap or clamp depending on the build.
`ifdef DEEMPH_SAT_EN
   logic signed [32:0] sum33;
   always_comb begin
      sum33 = 33'(term_q) + 33'(term_m);
      if (sum33[32] != sum33[31])
         y_new = sum33[32] ? 32'sh8000_0000 : 32'sh7FFF_FFFF;
      else
         y_new = sum33[31:0];
   end
`else
   always_comb begin
      y_new = term_q + term_m;
   end
`endif

   // Main sequencer.
   // Coefficients are staged on any cycle but only become active at accept.
   // A strobe coincident with accept goes straight into the active set.
   // Feedback state is cleared on a rising enable, so a re-enabled filter starts from rest.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
         out_l     <= '0;
         out_r     <= '0;
         busy      <= 1'b0;
         xl        <= '0;
         xr        <= '0;
         yl        <= '0;
         yr        <= '0;
         en_q      <= 1'b0;
         term_q    <= '0;
         a_act     <= A_INIT;
         b_act     <= B_INIT;
         a_stg     <= A_INIT;
         b_stg     <= B_INIT;
      end else begin
         if (coef_load) begin
            a_stg <= coef_a;
            b_stg <= coef_b;
         end
         case (state)
            IDLE: begin
               if (in_valid && in_ready) begin
                  xl       <= in_l;
                  xr       <= in_r;
                  en_q     <= enable;
                  a_act    <= coef_load ? coef_a : a_stg;
                  b_act    <= coef_load ? coef_b : b_stg;
                  in_ready <= 1'b0;
                  busy     <= 1'b1;
                  if (enable) begin
                     if (!en_q) begin
                        yl <= '0;
                        yr <= '0;
                     end
                     state <= ML_X;
                  end else begin
                     out_l     <= in_l;
                     out_r     <= in_r;
                     out_valid <= 1'b1;
                     state     <= HOLD;
                  end
               end else begin
                  in_ready <= 1'b1;
               end
            end
            ML_X: begin
               term_q <= term_m;
               state  <= ML_Y;
            end
            ML_Y: begin
               yl    <= y_new;
               out_l <= y_new[31:8];
               state <= MR_X;
            end
            MR_X: begin
               term_q <= term_m;
               state  <= MR_Y;
            end
            MR_Y: begin
               yr        <= y_new;
               out_r     <= y_new[31:8];
               out_valid <= 1'b1;
               state     <= HOLD;
            end
            HOLD: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  busy      <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_deemph_mac_sched.sv
// tb_deemph_mac_sched
// Directed bench for deemph_mac_sched.
// Expected frames come from an arithmetic model of the filter.
// They are queued at accept and compared when the DUT presents its output.

module tb_deemph_mac_sched;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [23:0] in_l = '0;
   logic [23:0] in_r = '0;
   logic        enable = 1'b0;
   logic        coef_load = 1'b0;
   logic [15:0] coef_a = '0;
   logic [15:0] coef_b = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [23:0] out_l, out_r;
   logic        busy;

   typedef struct {
      logic [23:0] l;
      logic [23:0] r;
      int          lat;
   } exp_t;

   exp_t sb[$];
   int   nCompared = 0;
   int   nMismatched = 0;

   // Model state
   logic signed [31:0] mYl = '0;
   logic signed [31:0] mYr = '0;
   logic               mEnq = 1'b0;
   logic signed [15:0] mStgA = 16'sd32000;
   logic signed [15:0] mStgB = 16'sd512;
   logic [23:0]        lastL, lastR;

   deemph_mac_sched dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_l(in_l), .in_r(in_r), .enable(enable),
      .coef_load(coef_load), .coef_a(coef_a), .coef_b(coef_b),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_l(out_l), .out_r(out_r), .busy(busy)
   );

   always #5 clk = ~clk;

   // Hard time limit so a stuck DUT still ends the run
   initial begin
      #400000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // One filter step in plain integer arithmetic
   function automatic logic signed [31:0] modelY(input logic [23:0] x,
                                                 input logic signed [31:0] yp,
                                                 input logic signed [15:0] a,
                                                 input logic signed [15:0] b);
      longint             xe, t1, t2, s;
      logic signed [31:0] t1w, t2w;
      xe  = longint'($signed({x, 8'h00}));
      t1  = (xe * longint'(a)) >>> 15;
      t2  = (longint'(yp) * longint'(b)) >>> 15;
      t1w = t1[31:0];
      t2w = t2[31:0];
      s   = longint'(t1w) + longint'(t2w);
`ifdef DEEMPH_SAT_EN
      if (s > 64'sd2147483647)  s = 64'sd2147483647;
      if (s < -64'sd2147483648) s = -64'sd2147483648;
`endif
      return s[31:0];
   endfunction

   task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nCompared++;
      assert (obs === exp) else begin
         nMismatched++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Offer one frame and wait (bounded) for acceptance.
   // On accept, update the model and queue the expected result.
   task automatic applyStimulus(input logic [23:0] l, input logic [23:0] r, input logic en,
                                input logic ld, input logic [15:0] la, input logic [15:0] lb);
      int   waitCyc = 0;
      exp_t e;
      logic signed [15:0] actA, actB;
      in_l = l; in_r = r; enable = en; in_valid = 1'b1;
      while (!in_ready && waitCyc < 50) begin
         @(posedge clk); #1;
         waitCyc++;
      end
      checkVal("accept_ready", {31'b0, in_ready}, 32'd1);
      if (!in_ready) begin
         in_valid = 1'b0;
         return;
      end
      coef_load = ld; coef_a = la; coef_b = lb;
      if (ld) begin
         mStgA = la;
         mStgB = lb;
      end
      actA = mStgA;
      actB = mStgB;
      if (en) begin
         if (!mEnq) begin
            mYl = '0;
            mYr = '0;
         end
         mYl = modelY(l, mYl, actA, actB);
         mYr = modelY(r, mYr, actA, actB);
         e.l = mYl[31:8]; e.r = mYr[31:8]; e.lat = 5;
      end else begin
         e.l = l; e.r = r; e.lat = 1;
      end
      mEnq = en;
      sb.push_back(e);
      @(posedge clk); #1;
      in_valid = 1'b0;
      coef_load = 1'b0;
   endtask

   // Wait for out_valid, compare latency and data against the queue head.
   // Optionally pulse a coefficient load mid-frame.
   // When out_ready is high, the frame is then consumed.
   task automatic checkOutput(input string tag, input logic midLd,
                              input logic [15:0] la, input logic [15:0] lb);
      int   k = 1;
      exp_t e;
      while (!out_valid && k < 20) begin
         if (midLd && k == 2) begin
            coef_load = 1'b1; coef_a = la; coef_b = lb;
            mStgA = la; mStgB = lb;
         end
         @(posedge clk); #1;
         coef_load = 1'b0;
         k++;
      end
      checkVal({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
      if (sb.size() == 0) begin
         checkVal({tag, "_queue"}, 32'd0, 32'd1);
         return;
      end
      e = sb.pop_front();
      checkVal({tag, "_latency"}, k, e.lat);
      checkVal({tag, "_l"}, {8'b0, out_l}, {8'b0, e.l});
      checkVal({tag, "_r"}, {8'b0, out_r}, {8'b0, e.r});
      lastL = e.l;
      lastR = e.r;
      if (out_ready) begin
         @(posedge clk); #1;
      end
   endtask

   initial begin
      // Reset held for two cycles
      @(posedge clk); #1;
      @(posedge clk); #1;
      checkVal("rst_in_ready", {31'b0, in_ready}, 32'd0);
      checkVal("rst_out_valid", {31'b0, out_valid}, 32'd0);
      checkVal("rst_out_l", {8'b0, out_l}, 32'd0);
      checkVal("rst_out_r", {8'b0, out_r}, 32'd0);
      checkVal("rst_busy", {31'b0, busy}, 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;
      checkVal("rel_in_ready", {31'b0, in_ready}, 32'd1);
      checkVal("rel_busy", {31'b0, busy}, 32'd0);

      // Filter with the reset coefficients, two identical frames
      applyStimulus(24'h100000, 24'h100000, 1'b1, 1'b0, 16'd0, 16'd0);
      checkVal("run_busy", {31'b0, busy}, 32'd1);
      checkVal("run_in_ready", {31'b0, in_ready}, 32'd0);
      checkOutput("filt1", 1'b0, 16'd0, 16'd0);
      applyStimulus(24'h100000, 24'h100000, 1'b1, 1'b0, 16'd0, 16'd0);
      checkOutput("filt2", 1'b0, 16'd0, 16'd0);

      // Bypass
      applyStimulus(24'h123456, 24'hFEDCBA, 1'b0, 1'b0, 16'd0, 16'd0);
      checkOutput("bypass", 1'b0, 16'd0, 16'd0);

      // A frame offered while busy must wait for the current one to finish
      applyStimulus(24'h0C0000, 24'hF40000, 1'b1, 1'b0, 16'd0, 16'd0);
      in_valid = 1'b1; in_l = 24'h000777; in_r = 24'hFFF889;
      checkOutput("busy_hold", 1'b0, 16'd0, 16'd0);
      applyStimulus(24'h000777, 24'hFFF889, 1'b1, 1'b0, 16'd0, 16'd0);
      checkOutput("busy_next", 1'b0, 16'd0, 16'd0);

      // Backpressure: output held for 10 cycles
      out_ready = 1'b0;
      applyStimulus(24'h200000, 24'hE00000, 1'b1, 1'b0, 16'd0, 16'd0);
      checkOutput("bp", 1'b0, 16'd0, 16'd0);
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         checkVal("bp_valid", {31'b0, out_valid}, 32'd1);
         checkVal("bp_l", {8'b0, out_l}, {8'b0, lastL});
         checkVal("bp_r", {8'b0, out_r}, {8'b0, lastR});
         checkVal("bp_in_ready", {31'b0, in_ready}, 32'd0);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      checkVal("bp_done_valid", {31'b0, out_valid}, 32'd0);
      checkVal("bp_done_busy", {31'b0, busy}, 32'd0);
      checkVal("bp_done_in_ready", {31'b0, in_ready}, 32'd1);

      // Coefficient load mid-frame affects only the next frame
      applyStimulus(24'h100000, 24'h100000, 1'b1, 1'b0, 16'd0, 16'd0);
      checkOutput("coef_cur", 1'b1, 16'd16384, 16'd512);
      applyStimulus(24'h100000, 24'h100000, 1'b1, 1'b0, 16'd0, 16'd0);
      checkOutput("coef_next", 1'b0, 16'd0, 16'd0);

      // Saturation/wrap: bypass first so the next enable is a rising edge
      applyStimulus(24'h000000, 24'h000000, 1'b0, 1'b0, 16'd0, 16'd0);
      checkOutput("sat_pre", 1'b0, 16'd0, 16'd0);
      applyStimulus(24'h7FFFFF, 24'h7FFFFF, 1'b1, 1'b1, 16'd32767, 16'd32767);
      checkOutput("sat1", 1'b0, 16'd0, 16'd0);
      applyStimulus(24'h7FFFFF, 24'h7FFFFF, 1'b1, 1'b0, 16'd0, 16'd0);
      checkOutput("sat2", 1'b0, 16'd0, 16'd0);

      // Reset in the middle of a frame
      applyStimulus(24'h100000, 24'h080000, 1'b1, 1'b0, 16'd0, 16'd0);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      checkVal("mrst_valid", {31'b0, out_valid}, 32'd0);
      checkVal("mrst_busy", {31'b0, busy}, 32'd0);
      checkVal("mrst_in_ready", {31'b0, in_ready}, 32'd0);
      sb.delete();
      mYl = '0; mYr = '0; mEnq = 1'b0;
      mStgA = 16'sd32000; mStgB = 16'sd512;
      @(posedge clk); #1;
      checkVal("mrst_rel_in_ready", {31'b0, in_ready}, 32'd1);
      applyStimulus(24'h100000, 24'h080000, 1'b1, 1'b0, 16'd0, 16'd0);
      checkOutput("post_rst", 1'b0, 16'd0, 16'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
